lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit between the decode/execute stage and the data memory. It consumes the decoded memory-control signals (read enable, write enable, load/store width codes) and the ALU-computed address. It then runs a request/acknowledge transaction with data memory, generating byte lanes, replicating store data, and sign- or zero-extending load data. It stalls the pipeline for the duration of each access.

Parameters:
ADDR_W, 32, byte-address width on both the pipeline side and the memory side
TIMEOUT_CYC, 255, maximum cycles spent in REQ before a bus error; used only with LSU_TIMEOUT_EN

Ports:
i_clk  input  1  clock; all state changes on the rising edge
i_reset  input  1  synchronous, active-high reset
i_req  input  1  instruction in the execute stage is valid
i_rden  input  1  load instruction
i_mem_wren  input  1  store instruction
i_ld_rewrite  input  3  load width code: 0=LB, 1=LH, 2=LW, 3=LBU, 4=LHU, 5-7=none
i_st_rewrite  input  2  store width code: 0=SB, 1=SH, 2=SW, 3=none
i_addr  input  ADDR_W  effective byte address from the ALU
i_st_data  input  32  rs2 value for stores
o_stall  output  1  freeze the pipeline
o_done  output  1  one-cycle pulse: access complete
o_ld_data  output  32  extended load result; valid while o_done=1
o_misalign  output  1  one-cycle pulse: misaligned access rejected
o_bus_err  output  1  one-cycle pulse with o_done: access timed out
o_mem_req  output  1  memory request; held until acknowledged
o_mem_we  output  1  1=write, 0=read
o_mem_addr  output  ADDR_W  word-aligned address, {i_addr[ADDR_W-1:2],2'b00}
o_mem_wdata  output  32  lane-replicated store data
o_mem_bmask  output  4  byte-lane enables
i_mem_ack  input  1  memory completed the request; i_mem_rdata valid in the same cycle
i_mem_rdata  input  32  read word

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset: state=IDLE. o_mem_req, o_mem_we, o_done, o_misalign and o_bus_err are 0. o_mem_addr, o_mem_wdata, o_ld_data and o_mem_bmask are 0. Timeout counter is 0.
- Op decode:
  - Store when i_mem_wren=1 and i_st_rewrite!=3. A store takes priority if i_rden and i_mem_wren are both set.
  - Load when i_rden=1 and i_ld_rewrite<=4.
  - Anything else is a no-op: no access, no pulses.
- Misalignment: halfword ops with addr[0]=1, or word ops with addr[1:0]!=0, are misaligned. A valid misaligned op in IDLE raises o_misalign for one cycle (registered, next cycle), makes no memory access and never raises o_stall.
- States: IDLE, REQ, DONE.
- IDLE:
  - start = i_req & valid op & aligned.
  - On start: latch addr[1:0], width code, we, address and lane-formatted data; go to REQ.
  - o_stall = start (combinational), so the issuing cycle is already stalled.
- REQ:
  - o_mem_req=1; o_mem_* held stable; o_stall=1.
  - On i_mem_ack: capture the formatted load data, go to DONE.
  - The earliest ack is the first REQ cycle.
- DONE:
  - o_done=1, o_stall=0; the pipeline advances at the end of this cycle.
  - i_req is ignored (it is the same instruction); next state is IDLE.
- Latency: accept at cycle N, o_mem_req from N+1, ack at cycle M, o_done at M+1. The minimum is 2 cycles of stall.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, bmask=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, bmask=addr[1]?4'b1100:4'b0011.
  - SW: wdata=d, bmask=4'b1111.
- Load lanes: bmask is the same pattern as stores; we=0 and wdata=0.
- Load extension:
  - Byte select is rdata[8*addr[1:0]+:8]; half select is rdata[16*addr[1]+:16].
  - LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word unchanged.
- Store completion: a store also produces o_done; o_ld_data=0 for stores.
- Ack outside REQ is ignored.
- Reset mid-transaction: at the reset edge the block returns to IDLE. o_mem_req=0 from the next cycle, and no o_done is produced.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: the counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYC, o_mem_req drops and the block goes to DONE with o_bus_err=1 and o_ld_data=0. The counter clears on entry to REQ.
- Undefined: no counter is built, o_bus_err is tied to 0, and REQ waits indefinitely for i_mem_ack.

Test Plan:
1. LW, addr=0x104, ack 2 cycles after o_mem_req, rdata=0xDEADBEEF -> o_mem_addr=0x104, bmask=1111, we=0. o_done and o_ld_data=0xDEADBEEF arrive one cycle after ack. o_stall is high from the accept cycle through the ack cycle.
2. Load extension, rdata=0x80018000:
   - LB at 0x103 -> 0xFFFFFF80.
   - LBU at 0x103 -> 0x00000080.
   - LH at 0x102 -> 0xFFFF8001.
   - LHU at 0x100 -> 0x00008000.
3. Store lanes:
   - SB at 0x21, data=0x000000AB -> addr=0x20, wdata=0xABABABAB, bmask=0010, we=1, o_done after ack.
   - SH at 0x22, data=0x00001234 -> wdata=0x12341234, bmask=1100.
4. Misalignment: LW at 0x102 and SH at 0x33 -> o_misalign pulses one cycle each, o_mem_req stays 0, o_stall stays 0.
5. i_reset asserted in the 2nd REQ cycle, then ack one cycle later -> o_mem_req=0 after the reset edge, no o_done, state IDLE. A following LW at 0x0 completes normally.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYC=4, no ack -> o_mem_req drops after 4 REQ cycles, then o_done=1, o_bus_err=1, o_ld_data=0. A later stray ack is ignored.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes memory ops, runs a req/ack handshake with data
// memory, formats store lanes and extends load data. Stalls the pipeline while busy.
// Optional feature macro: LSU_TIMEOUT_EN (bounded wait in REQ, reports a bus error).
module lsu_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_rden,
  input  logic              i_mem_wren,
  input  logic [2:0]        i_ld_rewrite,
  input  logic [1:0]        i_st_rewrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_st_data,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_ld_data,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            r_state;
  logic              r_done, r_misalign, r_bus_err;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata, r_ld_data;
  logic [3:0]        r_mem_bmask;
  logic [1:0]        r_off, r_size;
  logic              r_sext;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]  r_cnt;
`endif

  // w_size: 0=byte, 1=half, 2=word
  logic       w_is_st, w_is_ld, w_misal, w_start, w_sext;
  logic [1:0] w_size;
  logic [31:0] w_wdata, w_ld_fmt;
  logic [3:0]  w_bmask;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Decode op kind, access size, signedness and alignment
  always_comb begin
    w_is_st = i_mem_wren & (i_st_rewrite != 2'd3);
    w_is_ld = ~w_is_st & i_rden & (i_ld_rewrite <= 3'd4);
    w_size  = 2'd2;
    w_sext  = 1'b0;
    if (w_is_st) begin
      w_size = i_st_rewrite;
    end else begin
      case (i_ld_rewrite)
        3'd0:    begin w_size = 2'd0; w_sext = 1'b1; end
        3'd1:    begin w_size = 2'd1; w_sext = 1'b1; end
        3'd3:    w_size = 2'd0;
        3'd4:    w_size = 2'd1;
        default: w_size = 2'd2;
      endcase
    end
    w_misal = ((w_size == 2'd1) & i_addr[0]) | ((w_size == 2'd2) & (|i_addr[1:0]));
    w_start = i_req & (w_is_st | w_is_ld) & ~w_misal;
  end

  // Byte-lane mask and replicated store data; loads drive zero write data
  always_comb begin
    case (w_size)
      2'd0: begin
        w_bmask = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_st_data[7:0]}};
      end
      2'd1: begin
        w_bmask = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        w_bmask = 4'b1111;
        w_wdata = i_st_data;
      end
    endcase
    if (!w_is_st) w_wdata = '0;
  end

  // Select and extend the returned word using the latched offset and size
  always_comb begin
    w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
    w_half = i_mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_size)
      2'd0:    w_ld_fmt = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_ld_fmt = {{16{r_sext & w_half[15]}}, w_half};
      default: w_ld_fmt = i_mem_rdata;
    endcase
  end

  // Control FSM with registered memory-side and status outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_bmask <= '0;
      r_ld_data   <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_sext      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state     <= StReq;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_st;
            r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_bmask <= w_bmask;
            r_off       <= i_addr[1:0];
            r_size      <= w_size;
            r_sext      <= w_sext;
`ifdef LSU_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end else if (i_req & (w_is_st | w_is_ld) & w_misal) begin
            r_misalign <= 1'b1;
          end
        end
        StReq: begin
          if (i_mem_ack) begin
            r_state   <= StDone;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_ld_data <= r_mem_we ? 32'd0 : w_ld_fmt;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == CntLast) begin
            r_state   <= StDone;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
            r_ld_data <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // The accept cycle stalls combinationally; REQ always stalls
  assign o_stall     = (r_state == StReq) | ((r_state == StIdle) & w_start);
  assign o_done      = r_done;
  assign o_ld_data   = r_ld_data;
  assign o_misalign  = r_misalign;
  assign o_bus_err   = r_bus_err;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_bmask = r_mem_bmask;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a transaction-level expectation model and a per-cycle
// compare process sampling on the falling edge.
module tb_lsu_ctrl;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset, i_req, i_rden, i_mem_wren, i_mem_ack;
  logic [2:0]    i_ld_rewrite;
  logic [1:0]    i_st_rewrite;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_st_data, i_mem_rdata;
  logic          o_stall, o_done, o_misalign, o_bus_err, o_mem_req, o_mem_we;
  logic [31:0]   o_ld_data, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_bmask;

  int total = 0;
  int bad   = 0;

  lsu_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_rden(i_rden),
    .i_mem_wren(i_mem_wren), .i_ld_rewrite(i_ld_rewrite), .i_st_rewrite(i_st_rewrite),
    .i_addr(i_addr), .i_st_data(i_st_data), .o_stall(o_stall), .o_done(o_done),
    .o_ld_data(o_ld_data), .o_misalign(o_misalign), .o_bus_err(o_bus_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata)
  );

  // Expected outputs for the current cycle
  logic        mon_en = 1'b0;
  logic        e_stall, e_req, e_done, e_mis, e_berr, e_we;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_bmask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("stall", 32'(o_stall), 32'(e_stall));
      chk("mem_req", 32'(o_mem_req), 32'(e_req));
      chk("done", 32'(o_done), 32'(e_done));
      chk("misalign", 32'(o_misalign), 32'(e_mis));
      chk("bus_err", 32'(o_bus_err), 32'(e_berr));
      if (e_req) begin
        chk("mem_we", 32'(o_mem_we), 32'(e_we));
        chk("mem_addr", o_mem_addr, e_addr);
        chk("mem_wdata", o_mem_wdata, e_wdata);
        chk("mem_bmask", 32'(o_mem_bmask), 32'(e_bmask));
      end
      if (e_done) chk("ld_data", o_ld_data, e_ld);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    e_stall = 0; e_req = 0; e_done = 0; e_mis = 0; e_berr = 0; e_we = 0;
    e_addr = 0; e_wdata = 0; e_ld = 0; e_bmask = 0;
  endtask

  // Access size in bytes (0 = no-op); store wins when both enables are set
  function automatic int op_bytes(input bit rd, input bit wr, input logic [2:0] ldc,
                                  input logic [1:0] stc, output bit is_st, output bit sgn);
    is_st = 0;
    sgn   = 0;
    if (wr && stc != 2'd3) begin
      is_st = 1;
      return (stc == 0) ? 1 : (stc == 1) ? 2 : 4;
    end
    if (rd && ldc <= 3'd4) begin
      sgn = (ldc == 0) || (ldc == 1);
      return (ldc == 0 || ldc == 3) ? 1 : (ldc == 1 || ldc == 4) ? 2 : 4;
    end
    return 0;
  endfunction

  // One full operation: accept, REQ for dly+1 cycles with ack on the last, DONE, idle.
  // lit_a/lit_b pin hand-computed values (load result, or store wdata/bmask).
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] ldc,
                        input logic [1:0] stc, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] rdata, input bit lit_en,
                        input logic [31:0] lit_a, input logic [3:0] lit_b);
    bit st, sgn;
    int n;
    logic [31:0] m, w, v;
    n = op_bytes(rd, wr, ldc, stc, st, sgn);
    step();
    i_req = 1; i_rden = rd; i_mem_wren = wr; i_ld_rewrite = ldc; i_st_rewrite = stc;
    i_addr = a; i_st_data = d; i_mem_ack = 0;
    clear_exp();
    if (n == 0) begin
      step(); i_req = 0; clear_exp();
      return;
    end
    if ((a % n) != 0) begin
      step(); i_req = 0; clear_exp(); e_mis = 1;
      step(); clear_exp();
      return;
    end
    e_stall = 1;
    m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    w = 0;
    for (int i = 0; i < 4 / n; i++) w = w | ((d & m) << (8 * n * i));
    for (int k = 0; k <= dly; k++) begin
      step();
      e_stall = 1; e_req = 1; e_we = st; e_addr = a & ~32'd3;
      e_wdata = st ? w : 32'd0;
      e_bmask = 4'(((1 << n) - 1) << (a % 4));
      if (k == 0 && lit_en && st) begin
        chk("lit_wdata", o_mem_wdata, lit_a);
        chk("lit_bmask", 32'(o_mem_bmask), 32'(lit_b));
      end
      if (k == dly) begin
        i_mem_ack = 1; i_mem_rdata = rdata;
      end
    end
    v = (rdata >> (8 * (a % 4))) & m;
    if (sgn && v[8 * n - 1]) v = v | ~m;
    step();
    i_mem_ack = 0; i_mem_rdata = 32'h5A5A_5A5A;
    clear_exp(); e_done = 1; e_ld = st ? 32'd0 : v;
    if (lit_en && !st) chk("lit_ld", o_ld_data, lit_a);
    step();
    i_req = 0; clear_exp();
  endtask

  initial begin
    i_reset = 1; i_req = 0; i_rden = 0; i_mem_wren = 0; i_mem_ack = 0;
    i_ld_rewrite = 0; i_st_rewrite = 0; i_addr = 0; i_st_data = 0; i_mem_rdata = 0;
    clear_exp();
    step(); step();
    chk("rst_req", 32'(o_mem_req), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_ld", o_ld_data, 0);
    chk("rst_bmask", 32'(o_mem_bmask), 0);
    i_reset = 0;
    mon_en = 1;

    // LW with ack two cycles after the request
    run_op(1, 0, 3'd2, 2'd3, 32'h104, 0, 2, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'h0);
    // Load extension
    run_op(1, 0, 3'd0, 2'd3, 32'h103, 0, 0, 32'h80018000, 1, 32'hFFFFFF80, 4'h0);
    run_op(1, 0, 3'd3, 2'd3, 32'h103, 0, 1, 32'h80018000, 1, 32'h00000080, 4'h0);
    run_op(1, 0, 3'd1, 2'd3, 32'h102, 0, 0, 32'h80018000, 1, 32'hFFFF8001, 4'h0);
    run_op(1, 0, 3'd4, 2'd3, 32'h100, 0, 0, 32'h80018000, 1, 32'h00008000, 4'h0);
    run_op(1, 0, 3'd0, 2'd3, 32'h101, 0, 0, 32'h00007F00, 1, 32'h0000007F, 4'h0);
    // Store lanes
    run_op(0, 1, 3'd0, 2'd0, 32'h21, 32'h000000AB, 1, 0, 1, 32'hABABABAB, 4'b0010);
    run_op(0, 1, 3'd0, 2'd1, 32'h22, 32'h00001234, 0, 0, 1, 32'h12341234, 4'b1100);
    run_op(1, 1, 3'd2, 2'd2, 32'h10, 32'hCAFEF00D, 3, 32'h11111111, 1, 32'hCAFEF00D, 4'hF);
    // Misaligned and no-op requests
    run_op(1, 0, 3'd2, 2'd3, 32'h102, 0, 0, 0, 0, 0, 4'h0);
    run_op(0, 1, 3'd0, 2'd1, 32'h33, 32'h55, 0, 0, 0, 0, 4'h0);
    run_op(1, 0, 3'd5, 2'd3, 32'h40, 0, 0, 0, 0, 0, 4'h0);
    run_op(0, 1, 3'd7, 2'd3, 32'h40, 0, 0, 0, 0, 0, 4'h0);

    // Reset during the second REQ cycle, ack arrives one cycle later
    step();
    i_req = 1; i_rden = 1; i_mem_wren = 0; i_ld_rewrite = 3'd2; i_addr = 32'h200;
    clear_exp(); e_stall = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h200; e_wdata = 0; e_bmask = 4'hF;
    end
    i_reset = 1;
    step();
    i_reset = 0; i_req = 0; i_mem_ack = 1; i_mem_rdata = 32'h12345678; clear_exp();
    step();
    i_mem_ack = 0; clear_exp();
    run_op(1, 0, 3'd2, 2'd3, 32'h0, 0, 0, 32'h0BADF00D, 1, 32'h0BADF00D, 4'h0);

`ifdef LSU_TIMEOUT_EN
    // No ack: four REQ cycles, then DONE with bus error
    step();
    i_req = 1; i_rden = 1; i_mem_wren = 0; i_ld_rewrite = 3'd2; i_addr = 32'h40;
    clear_exp(); e_stall = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h40; e_wdata = 0; e_bmask = 4'hF;
    end
    step();
    clear_exp(); e_done = 1; e_berr = 1; e_ld = 0;
    step();
    i_req = 0; i_mem_ack = 1; i_mem_rdata = 32'hFFFFFFFF; clear_exp();
    step();
    i_mem_ack = 0; clear_exp();
    step();
`endif

    step();
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
